decode: RTL and testbench
=========================

# decode

Decode stage of the single-cycle RV32I core, directly downstream of instruction fetch. It consumes the 32-bit instruction word and contains:
- the 32×32 architectural register file, written by the writeback path;
- the immediate generator;
- the main and ALU control decoders.

Its outputs drive the execute, memory and PC-select logic.

## Interface
- A_WIDTH, 32, address/instruction width
- D_WIDTH, 32, register data width
- R_ADDR, 5, register index width
- BYPASS, 0, 1 = same-cycle write-to-read forwarding inside register file
- clk  in  1  core clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- instr  in  A_WIDTH  instruction word from fetch
- regwrite_in  in  1  writeback write enable
- rd_in  in  R_ADDR  writeback destination index
- wd3  in  D_WIDTH  writeback data
- rd1  out  D_WIDTH  x[instr[19:15]]
- rd2  out  D_WIDTH  x[instr[24:20]]
- immext  out  D_WIDTH  sign-extended immediate
- rd  out  R_ADDR  instr[11:7]
- regwrite, memwrite, alusrc, branch, jump, jalr  out  1 each  control
- resultsrc  out  2  00 ALU, 01 memory, 10 pc_plus4, 11 immext (lui)
- aluctrl  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt
- illegal  out  1  unsupported instruction

## Operation
- Supported opcodes:
  - R 0110011: add, sub, and, or, xor, slt
  - I-ALU 0010011: addi, andi, ori, xori, slti
  - lw 0000011, f3=010
  - sw 0100011, f3=010
  - beq/bne 1100011
  - jal 1101111
  - jalr 1100111
  - lui 0110111
- Any other opcode or funct3 combination, including shifts:
  - illegal=1;
  - regwrite, memwrite, branch, jump and jalr all 0;
  - other outputs don't-care.
- ALU control:
  - R-type f3=000: sub when instr[30]=1, else add.
  - I-type f3=000 is always add.
  - beq/bne → sub.
  - lw/sw/jalr → add.
  - The branch condition polarity is instr[12], consumed downstream.
- Immediate formats and sign extension from bit 31:
  - I: instr[31:20]
  - S: {instr[31:25], instr[11:7]}
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - U: {instr[31:12], 12'b0}
  - R-type immext = 0.
- Register file:
  - Two combinational read ports, one synchronous write port.
  - x0 reads as 0 always; writes to x0 are discarded.

## Timing
- Decode and read paths are purely combinational: zero-cycle latency from instr to all outputs.
- Write: on a rising clk edge with regwrite_in=1 and rd_in≠0, x[rd_in] ← wd3.
- BYPASS=0: a read of rd_in in the write cycle returns the old value; the new value is visible after the edge.
- BYPASS=1: when regwrite_in=1 and rd_in≠0 matches a read index, that port returns wd3 in the same cycle.
- Reset behaviour:
  - rst asserted asynchronously clears x1..x31 to 0, so rd1=rd2=0 immediately.
  - While rst=1, regwrite and memwrite outputs are forced 0 and register writes are blocked.
  - Reset asserted during a write edge: reset wins and the register stays 0.
  - First write is accepted on the first rising edge after rst deasserts.
- Simultaneous write to x0 and read of x0: output 0 in both BYPASS modes.

## Structure
- Package decode_pkg:
  - opcode localparams
  - aluctrl_t enum (3-bit)
  - resultsrc_t enum (2-bit)
  - immsrc_t enum: I, S, B, J, U, NONE
- Sub-module regfile: parameters D_WIDTH, R_ADDR, BYPASS; ports clk, rst, a1, a2, a3, we3, wd3, rd1, rd2.
- Control decode and immediate generation live in decode as combinational logic.

## Test plan
- Reset then addi x1,x0,5 (0x00500093): immext=5, alusrc=1, regwrite=1, aluctrl=000, rd=1. Then write x1=5 via the writeback port; next cycle rd1 for instr[19:15]=1 reads 5.
- add x3,x1,x2 (0x002081B3) with x1=5, x2=7 preloaded: rd1=5, rd2=7, aluctrl=000, alusrc=0, resultsrc=00. Setting instr[30]=1 gives aluctrl=001.
- sw x3,8(x0) (0x00302423): memwrite=1, regwrite=0, immext=8. beq x1,x1,-4 (0xFE108EE3): branch=1, aluctrl=001, immext=0xFFFFFFFC.
- jal x1,16 (0x010000EF): jump=1, regwrite=1, resultsrc=10, immext=16. Opcode 0x7F: illegal=1, regwrite=memwrite=0.
- Write x0=0xDEAD: x0 still reads 0. Write x5=0x1234 with BYPASS=1 while reading x5: rd1=0x1234 in the same cycle. With BYPASS=0, the old value is returned.
- Assert rst mid-cycle with x5=0x1234: rd1 drops to 0 asynchronously. A write presented during reset is not stored.

Source files
------------

// File: rtl/decode_pkg.sv
// +----------------------------------------------------------------------+
// | decode_pkg : shared opcodes and control encodings for decode         |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
`default_nettype none

package decode_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_XOR = 3'b100,
      ALU_SLT = 3'b101
   } aluctrl_t;

   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_PC4 = 2'b10,
      RES_IMM = 2'b11
   } resultsrc_t;

   typedef enum logic [2:0] {
      IMM_I    = 3'd0,
      IMM_S    = 3'd1,
      IMM_B    = 3'd2,
      IMM_J    = 3'd3,
      IMM_U    = 3'd4,
      IMM_NONE = 3'd5
   } immsrc_t;

   // funct3 values implemented for both R-type and I-type ALU ops
   function automatic logic f3_is_alu(input logic [2:0] f3);
      return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b100) ||
             (f3 == 3'b110) || (f3 == 3'b111);
   endfunction

   function automatic aluctrl_t alu_from_f3(input logic [2:0] f3, input logic sub);
      aluctrl_t sel;
      case (f3)
         3'b000:  sel = sub ? ALU_SUB : ALU_ADD;
         3'b010:  sel = ALU_SLT;
         3'b100:  sel = ALU_XOR;
         3'b110:  sel = ALU_OR;
         3'b111:  sel = ALU_AND;
         default: sel = ALU_ADD;
      endcase
      return sel;
   endfunction

endpackage

`default_nettype wire

// File: rtl/decode_regfile.sv
// +----------------------------------------------------------------------+
// | regfile : 2R/1W register file, x0 hard-wired to zero, async clear    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module regfile #(
   parameter int D_WIDTH = 32,
   parameter int R_ADDR  = 5,
   parameter int BYPASS  = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [R_ADDR-1:0]  a1,
   input  logic [R_ADDR-1:0]  a2,
   input  logic [R_ADDR-1:0]  a3,
   input  logic               we3,
   input  logic [D_WIDTH-1:0] wd3,
   output logic [D_WIDTH-1:0] rd1,
   output logic [D_WIDTH-1:0] rd2
);

   localparam int N_REGS = 1 << R_ADDR;

   logic [D_WIDTH-1:0] regs_q [1:N_REGS-1];
   logic [D_WIDTH-1:0] regs_d [1:N_REGS-1];
   logic               wr_en;

   // rst also gates the write so a write held across a reset edge is lost
   assign wr_en = we3 && (a3 != '0) && !rst;

   always_comb begin
      regs_d = regs_q;
      if (wr_en) begin
         regs_d[a3] = wd3;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 1; i < N_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   generate
      if (BYPASS != 0) begin : g_bypass
         assign rd1 = (a1 == '0) ? '0 : ((wr_en && (a3 == a1)) ? wd3 : regs_q[a1]);
         assign rd2 = (a2 == '0) ? '0 : ((wr_en && (a3 == a2)) ? wd3 : regs_q[a2]);
      end else begin : g_no_bypass
         assign rd1 = (a1 == '0) ? '0 : regs_q[a1];
         assign rd2 = (a2 == '0) ? '0 : regs_q[a2];
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/decode.sv
// +----------------------------------------------------------------------+
// | decode : RV32I decode stage - control, immediates, register file     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module decode
   import decode_pkg::*;
#(
   parameter int A_WIDTH = 32,
   parameter int D_WIDTH = 32,
   parameter int R_ADDR  = 5,
   parameter int BYPASS  = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [A_WIDTH-1:0] instr,
   input  logic               regwrite_in,
   input  logic [R_ADDR-1:0]  rd_in,
   input  logic [D_WIDTH-1:0] wd3,
   output logic [D_WIDTH-1:0] rd1,
   output logic [D_WIDTH-1:0] rd2,
   output logic [D_WIDTH-1:0] immext,
   output logic [R_ADDR-1:0]  rd,
   output logic               regwrite,
   output logic               memwrite,
   output logic               alusrc,
   output logic               branch,
   output logic               jump,
   output logic               jalr,
   output logic [1:0]         resultsrc,
   output logic [2:0]         aluctrl,
   output logic               illegal
);

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        dec_regwrite;
   logic        dec_memwrite;
   immsrc_t     immsrc;
   aluctrl_t    alu_sel;
   resultsrc_t  res_sel;
   logic [31:0] imm32;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];

   always_comb begin
      illegal      = 1'b0;
      dec_regwrite = 1'b0;
      dec_memwrite = 1'b0;
      alusrc       = 1'b0;
      branch       = 1'b0;
      jump         = 1'b0;
      jalr         = 1'b0;
      res_sel      = RES_ALU;
      alu_sel      = ALU_ADD;
      immsrc       = IMM_NONE;
      case (opcode)
         OP_R: begin
            if (f3_is_alu(funct3)) begin
               dec_regwrite = 1'b1;
               alu_sel      = alu_from_f3(funct3, instr[30]);
            end else begin
               illegal = 1'b1;
            end
         end
         OP_I: begin
            if (f3_is_alu(funct3)) begin
               dec_regwrite = 1'b1;
               alusrc       = 1'b1;
               immsrc       = IMM_I;
               alu_sel      = alu_from_f3(funct3, 1'b0);
            end else begin
               illegal = 1'b1;
            end
         end
         OP_LOAD: begin
            if (funct3 == 3'b010) begin
               dec_regwrite = 1'b1;
               alusrc       = 1'b1;
               res_sel      = RES_MEM;
               immsrc       = IMM_I;
            end else begin
               illegal = 1'b1;
            end
         end
         OP_STORE: begin
            if (funct3 == 3'b010) begin
               dec_memwrite = 1'b1;
               alusrc       = 1'b1;
               immsrc       = IMM_S;
            end else begin
               illegal = 1'b1;
            end
         end
         OP_BRANCH: begin
            // only beq/bne; polarity travels downstream as instr[12]
            if (funct3[2:1] == 2'b00) begin
               branch  = 1'b1;
               alu_sel = ALU_SUB;
               immsrc  = IMM_B;
            end else begin
               illegal = 1'b1;
            end
         end
         OP_JAL: begin
            dec_regwrite = 1'b1;
            jump         = 1'b1;
            res_sel      = RES_PC4;
            immsrc       = IMM_J;
         end
         OP_JALR: begin
            if (funct3 == 3'b000) begin
               dec_regwrite = 1'b1;
               jump         = 1'b1;
               jalr         = 1'b1;
               alusrc       = 1'b1;
               res_sel      = RES_PC4;
               immsrc       = IMM_I;
            end else begin
               illegal = 1'b1;
            end
         end
         OP_LUI: begin
            dec_regwrite = 1'b1;
            alusrc       = 1'b1;
            res_sel      = RES_IMM;
            immsrc       = IMM_U;
         end
         default: illegal = 1'b1;
      endcase
   end

   assign regwrite  = dec_regwrite & ~rst;
   assign memwrite  = dec_memwrite & ~rst;
   assign resultsrc = res_sel;
   assign aluctrl   = alu_sel;
   assign rd        = instr[7 +: R_ADDR];

   always_comb begin
      case (immsrc)
         IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
         IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_J:   imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
         IMM_U:   imm32 = {instr[31:12], 12'b0};
         default: imm32 = 32'b0;
      endcase
   end

   assign immext = D_WIDTH'($signed(imm32));

   regfile #(
      .D_WIDTH (D_WIDTH),
      .R_ADDR  (R_ADDR),
      .BYPASS  (BYPASS)
   ) u_regfile (
      .clk (clk),
      .rst (rst),
      .a1  (instr[15 +: R_ADDR]),
      .a2  (instr[20 +: R_ADDR]),
      .a3  (rd_in),
      .we3 (regwrite_in),
      .wd3 (wd3),
      .rd1 (rd1),
      .rd2 (rd2)
   );

endmodule

`default_nettype wire

// File: tb/tb_decode.sv
// +----------------------------------------------------------------------+
// | tb_decode : directed + random checks of decode against a model       |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_decode;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] instr = '0;
   logic        regwrite_in = 1'b0;
   logic [4:0]  rd_in = '0;
   logic [31:0] wd3 = '0;

   logic [31:0] rd1_0, rd2_0, immext_0, rd1_1, rd2_1, immext_1;
   logic [4:0]  rd_0, rd_1;
   logic        regwrite_0, memwrite_0, alusrc_0, branch_0, jump_0, jalr_0, illegal_0;
   logic        regwrite_1, memwrite_1, alusrc_1, branch_1, jump_1, jalr_1, illegal_1;
   logic [1:0]  resultsrc_0, resultsrc_1;
   logic [2:0]  aluctrl_0, aluctrl_1;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] ref_x [0:31];
   logic [6:0]  ops [0:7];

   always #5 clk = ~clk;

   decode #(.BYPASS(0)) dut_b0 (
      .clk(clk), .rst(rst), .instr(instr), .regwrite_in(regwrite_in), .rd_in(rd_in),
      .wd3(wd3), .rd1(rd1_0), .rd2(rd2_0), .immext(immext_0), .rd(rd_0),
      .regwrite(regwrite_0), .memwrite(memwrite_0), .alusrc(alusrc_0), .branch(branch_0),
      .jump(jump_0), .jalr(jalr_0), .resultsrc(resultsrc_0), .aluctrl(aluctrl_0),
      .illegal(illegal_0)
   );

   decode #(.BYPASS(1)) dut_b1 (
      .clk(clk), .rst(rst), .instr(instr), .regwrite_in(regwrite_in), .rd_in(rd_in),
      .wd3(wd3), .rd1(rd1_1), .rd2(rd2_1), .immext(immext_1), .rd(rd_1),
      .regwrite(regwrite_1), .memwrite(memwrite_1), .alusrc(alusrc_1), .branch(branch_1),
      .jump(jump_1), .jalr(jalr_1), .resultsrc(resultsrc_1), .aluctrl(aluctrl_1),
      .illegal(illegal_1)
   );

   typedef struct {
      logic        ill, rw, mw, br, jp, jr, asrc;
      logic [1:0]  rsrc;
      logic [2:0]  alu;
      logic [31:0] imm;
      bit          k_asrc, k_rsrc, k_alu, k_imm, k_jp;
   } exp_t;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h instr=%h", tag, got, exp, instr);
      end
   endtask

   // Reference decode built from the instruction-set rules with integer arithmetic
   function automatic exp_t model(input logic [31:0] ins);
      exp_t e;
      int   si;
      int   f3;
      bit   alu_ok;
      int   alu_code;
      si = $signed(ins);
      f3 = int'(ins[14:12]);
      e = '{default: 0};
      e.k_jp = 1;
      alu_ok = (f3 == 0) || (f3 == 2) || (f3 == 4) || (f3 == 6) || (f3 == 7);
      alu_code = (f3 == 7) ? 2 : (f3 == 6) ? 3 : (f3 == 4) ? 4 : (f3 == 2) ? 5 : 0;
      case (ins[6:0])
         7'b0110011: if (alu_ok) begin
            e.rw = 1; e.asrc = 0; e.rsrc = 0; e.imm = 0;
            e.alu = 3'(alu_code + ((f3 == 0 && ins[30]) ? 1 : 0));
            e.k_asrc = 1; e.k_rsrc = 1; e.k_alu = 1; e.k_imm = 1;
         end else e.ill = 1;
         7'b0010011: if (alu_ok) begin
            e.rw = 1; e.asrc = 1; e.rsrc = 0; e.alu = 3'(alu_code); e.imm = si >>> 20;
            e.k_asrc = 1; e.k_rsrc = 1; e.k_alu = 1; e.k_imm = 1;
         end else e.ill = 1;
         7'b0000011: if (f3 == 2) begin
            e.rw = 1; e.asrc = 1; e.rsrc = 1; e.alu = 0; e.imm = si >>> 20;
            e.k_asrc = 1; e.k_rsrc = 1; e.k_alu = 1; e.k_imm = 1;
         end else e.ill = 1;
         7'b0100011: if (f3 == 2) begin
            e.mw = 1; e.asrc = 1; e.alu = 0;
            e.imm = (si >>> 25) * 32 + int'(ins[11:7]);
            e.k_asrc = 1; e.k_alu = 1; e.k_imm = 1;
         end else e.ill = 1;
         7'b1100011: if (f3 < 2) begin
            e.br = 1; e.asrc = 0; e.alu = 1;
            e.imm = (si >>> 31) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 +
                    int'(ins[11:8]) * 2;
            e.k_asrc = 1; e.k_alu = 1; e.k_imm = 1;
         end else e.ill = 1;
         7'b1101111: begin
            e.jp = 1; e.rw = 1; e.rsrc = 2;
            e.imm = (si >>> 31) * (1 << 20) + int'(ins[19:12]) * 4096 +
                    int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
            e.k_rsrc = 1; e.k_imm = 1;
         end
         7'b1100111: if (f3 == 0) begin
            e.jr = 1; e.rw = 1; e.rsrc = 2; e.asrc = 1; e.alu = 0; e.imm = si >>> 20;
            e.k_jp = 0; e.k_asrc = 1; e.k_rsrc = 1; e.k_alu = 1; e.k_imm = 1;
         end else e.ill = 1;
         7'b0110111: begin
            e.rw = 1; e.rsrc = 3; e.imm = ins & 32'hFFFF_F000;
            e.k_rsrc = 1; e.k_imm = 1;
         end
         default: e.ill = 1;
      endcase
      return e;
   endfunction

   task automatic check_ctrl(input exp_t e);
      check_eq("illegal", 32'(illegal_0), 32'(e.ill));
      check_eq("regwrite", 32'(regwrite_0), 32'(e.rw && !rst));
      check_eq("memwrite", 32'(memwrite_0), 32'(e.mw && !rst));
      check_eq("branch", 32'(branch_0), 32'(e.br));
      check_eq("jalr", 32'(jalr_0), 32'(e.jr));
      check_eq("rd", 32'(rd_0), 32'(instr[11:7]));
      if (e.k_jp)   check_eq("jump", 32'(jump_0), 32'(e.jp));
      if (e.k_asrc) check_eq("alusrc", 32'(alusrc_0), 32'(e.asrc));
      if (e.k_rsrc) check_eq("resultsrc", 32'(resultsrc_0), 32'(e.rsrc));
      if (e.k_alu)  check_eq("aluctrl", 32'(aluctrl_0), 32'(e.alu));
      if (e.k_imm)  check_eq("immext", immext_0, e.imm);
   endtask

   task automatic check_regs();
      logic [4:0]  rs1, rs2;
      logic        fwd_ok;
      rs1 = instr[19:15];
      rs2 = instr[24:20];
      fwd_ok = regwrite_in && !rst && (rd_in != 0);
      check_eq("rd1_nobyp", rd1_0, ref_x[rs1]);
      check_eq("rd2_nobyp", rd2_0, ref_x[rs2]);
      check_eq("rd1_byp", rd1_1, (fwd_ok && rd_in == rs1) ? wd3 : ref_x[rs1]);
      check_eq("rd2_byp", rd2_1, (fwd_ok && rd_in == rs2) ? wd3 : ref_x[rs2]);
   endtask

   task automatic clear_ref();
      for (int i = 0; i < 32; i++) ref_x[i] = '0;
   endtask

   // Advance one clock; the model commits the write seen at the rising edge
   task automatic tick();
      @(posedge clk);
      if (!rst && regwrite_in && rd_in != 0) ref_x[rd_in] = wd3;
      @(negedge clk);
   endtask

   initial begin
      exp_t        e;
      logic [31:0] ins;
      ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011; ops[3] = 7'b0100011;
      ops[4] = 7'b1100011; ops[5] = 7'b1101111; ops[6] = 7'b1100111; ops[7] = 7'b0110111;
      clear_ref();

      #1 rst = 1'b1;
      instr = 32'h0050_0093;
      #2;
      check_eq("rst_rd1_nobyp", rd1_0, 32'h0);
      check_eq("rst_rd1_byp", rd1_1, 32'h0);
      check_eq("rst_regwrite", 32'(regwrite_0), 32'h0);
      instr = 32'h0030_2423;
      #1 check_eq("rst_memwrite", 32'(memwrite_0), 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      instr = 32'h0050_0093;
      #2;
      check_eq("addi_imm", immext_0, 32'd5);
      check_eq("addi_alusrc", 32'(alusrc_0), 32'h1);
      check_eq("addi_regwrite", 32'(regwrite_0), 32'h1);
      check_eq("addi_aluctrl", 32'(aluctrl_0), 32'h0);
      check_eq("addi_rd", 32'(rd_0), 32'h1);
      regwrite_in = 1'b1; rd_in = 5'd1; wd3 = 32'd5;
      tick();
      rd_in = 5'd2; wd3 = 32'd7; instr = 32'h0020_81B3;
      #2 check_eq("x1_written", rd1_0, 32'd5);
      tick();
      regwrite_in = 1'b0;
      #2;
      check_eq("add_rd1", rd1_0, 32'd5);
      check_eq("add_rd2", rd2_0, 32'd7);
      check_eq("add_aluctrl", 32'(aluctrl_0), 32'h0);
      check_eq("add_alusrc", 32'(alusrc_0), 32'h0);
      check_eq("add_resultsrc", 32'(resultsrc_0), 32'h0);
      instr = 32'h4020_81B3;
      #1 check_eq("sub_aluctrl", 32'(aluctrl_0), 32'h1);

      instr = 32'h0030_2423;
      #1;
      check_eq("sw_memwrite", 32'(memwrite_0), 32'h1);
      check_eq("sw_regwrite", 32'(regwrite_0), 32'h0);
      check_eq("sw_imm", immext_0, 32'd8);
      instr = 32'hFE10_8EE3;
      #1;
      check_eq("beq_branch", 32'(branch_0), 32'h1);
      check_eq("beq_aluctrl", 32'(aluctrl_0), 32'h1);
      check_eq("beq_imm", immext_0, 32'hFFFF_FFFC);
      instr = 32'h0100_00EF;
      #1;
      check_eq("jal_jump", 32'(jump_0), 32'h1);
      check_eq("jal_regwrite", 32'(regwrite_0), 32'h1);
      check_eq("jal_resultsrc", 32'(resultsrc_0), 32'h2);
      check_eq("jal_imm", immext_0, 32'd16);
      instr = 32'h0000_007F;
      #1;
      check_eq("bad_illegal", 32'(illegal_0), 32'h1);
      check_eq("bad_regwrite", 32'(regwrite_0), 32'h0);
      check_eq("bad_memwrite", 32'(memwrite_0), 32'h0);

      @(negedge clk);
      instr = 32'h0000_0013; regwrite_in = 1'b1; rd_in = 5'd0; wd3 = 32'h0000_DEAD;
      #2;
      check_eq("x0_same_nobyp", rd1_0, 32'h0);
      check_eq("x0_same_byp", rd1_1, 32'h0);
      tick();
      regwrite_in = 1'b0;
      #2 check_eq("x0_after", rd1_0, 32'h0);

      instr = 32'h0002_8013; regwrite_in = 1'b1; rd_in = 5'd5; wd3 = 32'h0000_1234;
      #1;
      check_eq("x5_byp_same", rd1_1, 32'h1234);
      check_eq("x5_nobyp_old", rd1_0, 32'h0);
      tick();
      regwrite_in = 1'b0;
      #2;
      check_eq("x5_nobyp_after", rd1_0, 32'h1234);
      check_eq("x5_byp_after", rd1_1, 32'h1234);

      #1 rst = 1'b1;
      clear_ref();
      #1;
      check_eq("async_rst_nobyp", rd1_0, 32'h0);
      check_eq("async_rst_byp", rd1_1, 32'h0);
      regwrite_in = 1'b1; rd_in = 5'd5; wd3 = 32'h0000_5555;
      #1 check_eq("rst_blocks_byp", rd1_1, 32'h0);
      tick();
      rst = 1'b0; regwrite_in = 1'b0;
      #2 check_eq("rst_write_lost", rd1_0, 32'h0);
      regwrite_in = 1'b1; wd3 = 32'h0000_0077;
      tick();
      regwrite_in = 1'b0;
      #2 check_eq("first_write", rd1_0, 32'h77);

      repeat (400) begin
         ins = $urandom;
         if ($urandom_range(0, 8) != 8) ins[6:0] = ops[$urandom_range(0, 7)];
         regwrite_in = 1'($urandom_range(0, 1));
         rd_in = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
         wd3 = $urandom;
         if ($urandom_range(0, 3) == 0) ins[19:15] = rd_in;
         if ($urandom_range(0, 3) == 0) ins[24:20] = rd_in;
         instr = ins;
         #2;
         e = model(ins);
         check_ctrl(e);
         check_regs();
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
